// File: rtl/branch_predictor.sv
// Branch unit: BHT (2-bit counters) + tagged BTB for IF prediction, EX resolve/update with registered redirect.
// Latency: prediction is combinational; redirect is registered, one cycle after the mispredicting EX cycle.
// Backpressure: none; EX in the redirect cycle is wrong-path and squashed. Optional statistics via BP_STATS_EN.
module branch_predictor #(
    parameter int         XLEN      = 32,
    parameter int         BHT_DEPTH = 64,
    parameter logic [1:0] CNT_INIT  = 2'b01
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            if_valid,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [3:0]      ex_branch_sel,
    input  logic [XLEN-1:0] ex_sr1,
    input  logic [XLEN-1:0] ex_sr2,
    input  logic [XLEN-1:0] ex_imm,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     branch_cnt,
    output logic [31:0]     mispred_cnt
);

    localparam int IDX_W = $clog2(BHT_DEPTH);
    localparam int TAG_W = XLEN - IDX_W - 2;

    localparam logic [3:0] SEL_OFFPC = 4'd1;
    localparam logic [3:0] SEL_NE    = 4'd2;
    localparam logic [3:0] SEL_EQ    = 4'd3;
    localparam logic [3:0] SEL_LT    = 4'd4;
    localparam logic [3:0] SEL_LTU   = 4'd5;
    localparam logic [3:0] SEL_GE    = 4'd6;
    localparam logic [3:0] SEL_GEU   = 4'd7;
    localparam logic [3:0] SEL_JALR  = 4'd8;

    localparam logic [XLEN-1:0] JALR_MASK = {{(XLEN-1){1'b1}}, 1'b0};

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
    } btb_ent_t;

    logic [1:0]           cnt_q [BHT_DEPTH];
    logic [BHT_DEPTH-1:0] btb_vld_q;
    btb_ent_t             btb_q [BHT_DEPTH];

    // ---------------- IF-side prediction ----------------
    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             if_hit;

    assign if_idx      = if_pc[IDX_W+1:2];
    assign if_tag      = if_pc[XLEN-1:IDX_W+2];
    assign if_hit      = btb_vld_q[if_idx] && (btb_q[if_idx].tag == if_tag);
    assign pred_taken  = if_valid && if_hit && cnt_q[if_idx][1];
    assign pred_target = pred_taken ? btb_q[if_idx].target : if_pc + XLEN'(4);

    // ---------------- EX-side resolve ----------------
    logic             ex_is_br;
    logic             ex_taken;
    logic [XLEN-1:0]  ex_target;
    logic [XLEN-1:0]  jalr_sum;
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             ex_upd;
    logic             mispred;
    logic [1:0]       cnt_nxt;

    always_comb begin
        ex_is_br = 1'b0;
        ex_taken = 1'b0;
        case (ex_branch_sel)
            SEL_OFFPC: begin ex_is_br = 1'b1; ex_taken = 1'b1; end
            SEL_NE:    begin ex_is_br = 1'b1; ex_taken = (ex_sr1 != ex_sr2); end
            SEL_EQ:    begin ex_is_br = 1'b1; ex_taken = (ex_sr1 == ex_sr2); end
            SEL_LT:    begin ex_is_br = 1'b1; ex_taken = ($signed(ex_sr1) < $signed(ex_sr2)); end
            SEL_LTU:   begin ex_is_br = 1'b1; ex_taken = (ex_sr1 < ex_sr2); end
            SEL_GE:    begin ex_is_br = 1'b1; ex_taken = ($signed(ex_sr1) >= $signed(ex_sr2)); end
            SEL_GEU:   begin ex_is_br = 1'b1; ex_taken = (ex_sr1 >= ex_sr2); end
            SEL_JALR:  begin ex_is_br = 1'b1; ex_taken = 1'b1; end
            default:   ;
        endcase
    end

    assign jalr_sum  = ex_sr1 + ex_imm;
    assign ex_target = (ex_branch_sel == SEL_JALR) ? (jalr_sum & JALR_MASK) : ex_pc + ex_imm;
    assign ex_idx    = ex_pc[IDX_W+1:2];
    assign ex_tag    = ex_pc[XLEN-1:IDX_W+2];

    // An EX op arriving while redirect is high is wrong-path and must leave no trace.
    assign ex_upd  = ex_valid && ex_is_br && !redirect;
    assign mispred = ex_upd && ((ex_taken != ex_pred_taken) ||
                                (ex_taken && ex_pred_taken && (ex_pred_target != ex_target)));

    always_comb begin
        cnt_nxt = cnt_q[ex_idx];
        if (ex_taken) begin
            if (cnt_nxt != 2'b11) cnt_nxt = cnt_nxt + 2'd1;
        end else begin
            if (cnt_nxt != 2'b00) cnt_nxt = cnt_nxt - 2'd1;
        end
    end

    // ---------------- table state ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < BHT_DEPTH; i++) cnt_q[i] <= CNT_INIT;
            btb_vld_q <= '0;
        end else if (ex_upd) begin
            cnt_q[ex_idx] <= cnt_nxt;
            if (ex_taken) btb_vld_q[ex_idx] <= 1'b1;
        end
    end

    // Tag/target payload is qualified by btb_vld_q, so it needs no reset.
    always_ff @(posedge clk) begin
        if (ex_upd && ex_taken) begin
            btb_q[ex_idx] <= '{tag: ex_tag, target: ex_target};
        end
    end

    // ---------------- redirect ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            redirect    <= 1'b0;
            redirect_pc <= '0;
        end else begin
            redirect <= mispred;
            if (mispred) redirect_pc <= ex_taken ? ex_target : ex_pc + XLEN'(4);
        end
    end

    // ---------------- statistics ----------------
`ifdef BP_STATS_EN
    logic [31:0] branch_cnt_q;
    logic [31:0] mispred_cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (ex_upd && (branch_cnt_q != 32'hFFFF_FFFF))  branch_cnt_q  <= branch_cnt_q + 32'd1;
            if (mispred && (mispred_cnt_q != 32'hFFFF_FFFF)) mispred_cnt_q <= mispred_cnt_q + 32'd1;
        end
    end

    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;
`else
    assign branch_cnt  = '0;
    assign mispred_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: reference table model plus a redirect scoreboard.
module tb_branch_predictor;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        if_valid = 1'b0;
    logic [31:0] if_pc = '0;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_pc = '0;
    logic [3:0]  ex_branch_sel = '0;
    logic [31:0] ex_sr1 = '0, ex_sr2 = '0, ex_imm = '0;
    logic        ex_pred_taken = 1'b0;
    logic [31:0] ex_pred_target = '0;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] branch_cnt, mispred_cnt;

    branch_predictor #(.XLEN(32), .BHT_DEPTH(DEPTH), .CNT_INIT(2'b01)) dut (
        .clk(clk), .rstn(rstn),
        .if_valid(if_valid), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_branch_sel(ex_branch_sel),
        .ex_sr1(ex_sr1), .ex_sr2(ex_sr2), .ex_imm(ex_imm),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        vld;
        logic [31:0] pc;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;

    logic [1:0]  m_cnt [DEPTH];
    logic        m_val [DEPTH];
    logic [23:0] m_tag [DEPTH];
    logic [31:0] m_tgt [DEPTH];
    logic [31:0] m_rpc;
    int          m_bcnt, m_mcnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_cnt[i] = 2'b01;
            m_val[i] = 1'b0;
            m_tag[i] = '0;
            m_tgt[i] = '0;
        end
        m_rpc  = '0;
        m_bcnt = 0;
        m_mcnt = 0;
    endtask

    function automatic logic m_pred(input logic [31:0] pc);
        return m_val[pc[7:2]] && (m_tag[pc[7:2]] == pc[31:8]) && m_cnt[pc[7:2]][1];
    endfunction

    task automatic check_pred(input string tag, input logic [31:0] pc);
        logic tk;
        if_valid = 1'b1;
        if_pc    = pc;
        #1;
        tk = m_pred(pc);
        chk({tag, ".tk"}, {31'd0, pred_taken}, {31'd0, tk});
        chk({tag, ".tgt"}, pred_target, tk ? m_tgt[pc[7:2]] : pc + 32'd4);
    endtask

    function automatic logic ref_taken(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
        case (sel)
            4'd1, 4'd8: return 1'b1;
            4'd2:       return a != b;
            4'd3:       return a == b;
            4'd4:       return $signed(a) < $signed(b);
            4'd5:       return a < b;
            4'd6:       return $signed(a) >= $signed(b);
            4'd7:       return a >= b;
            default:    return 1'b0;
        endcase
    endfunction

    // Drive one EX op (caller sits mid-cycle), check the same-cycle lookup, push the expected redirect, update the model.
    task automatic drive_ex(input string tag, input logic [3:0] sel, input logic [31:0] pc,
                            input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                            input logic pt, input logic [31:0] ptgt);
        exp_t        e;
        logic        br, tk, mis;
        logic [31:0] tgt;
        logic [5:0]  ix;
        ex_valid = 1'b1; ex_pc = pc; ex_branch_sel = sel;
        ex_sr1 = a; ex_sr2 = b; ex_imm = imm;
        ex_pred_taken = pt; ex_pred_target = ptgt;
        check_pred({tag, ".rdw"}, pc);
        br  = (sel >= 4'd1) && (sel <= 4'd8);
        tk  = ref_taken(sel, a, b);
        tgt = (sel == 4'd8) ? ((a + imm) & 32'hFFFF_FFFE) : pc + imm;
        mis = br && ((tk != pt) || (tk && pt && (ptgt != tgt)));
        if (mis) m_rpc = tk ? tgt : pc + 32'd4;
        e.vld = mis;
        e.pc  = m_rpc;
        sb.push_back(e);
        if (br) begin
            ix = pc[7:2];
            m_bcnt++;
            if (mis) m_mcnt++;
            if (tk) begin
                if (m_cnt[ix] != 2'b11) m_cnt[ix] = m_cnt[ix] + 2'd1;
                m_val[ix] = 1'b1;
                m_tag[ix] = pc[31:8];
                m_tgt[ix] = tgt;
            end else if (m_cnt[ix] != 2'b00) begin
                m_cnt[ix] = m_cnt[ix] - 2'd1;
            end
        end
    endtask

    task automatic check_redirect(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, ".redir"}, {31'd0, redirect}, {31'd0, e.vld});
            chk({tag, ".rpc"}, redirect_pc, e.pc);
        end
    endtask

    task automatic resolve(input string tag, input logic [3:0] sel, input logic [31:0] pc,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                           input logic pt, input logic [31:0] ptgt);
        drive_ex(tag, sel, pc, a, b, imm, pt, ptgt);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        @(negedge clk);
        check_redirect(tag);
        @(posedge clk); #1;
        chk({tag, ".pulse"}, {31'd0, redirect}, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pcs [4];
        logic [31:0] vals [4];
        logic [3:0]  sel;
        logic [31:0] pc, imm;
        logic        pt;

        pcs  = '{32'h0000_0100, 32'h0000_0104, 32'h0000_1100, 32'h0000_0240};
        vals = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'd5};

        model_reset();
        repeat (2) @(negedge clk);
        chk("rst.redir", {31'd0, redirect}, 32'd0);
        chk("rst.rpc", redirect_pc, 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        check_pred("rst.pred", 32'h100);
        chk("rst.bcnt", branch_cnt, 32'd0);
        chk("rst.mcnt", mispred_cnt, 32'd0);

        // BEQ taken, mispredicted, then predicted correctly
        resolve("beq1", 4'd3, 32'h100, 32'd5, 32'd5, 32'h40, 1'b0, 32'h0);
        resolve("beq2", 4'd3, 32'h100, 32'd5, 32'd5, 32'h40, 1'b1, 32'h140);
        check_pred("beq.pred", 32'h100);
        chk("beq.plan", {31'd0, pred_taken}, 32'd1);

        // saturate, then walk down 11->10->01
        resolve("beq3", 4'd3, 32'h100, 32'd5, 32'd5, 32'h40, 1'b1, 32'h140);
        resolve("beq4", 4'd3, 32'h100, 32'd5, 32'd5, 32'h40, 1'b1, 32'h140);
        resolve("nt1", 4'd3, 32'h100, 32'd5, 32'd6, 32'h40, 1'b1, 32'h140);
        check_pred("nt1.pred", 32'h100);
        chk("nt1.plan", {31'd0, pred_taken}, 32'd1);
        resolve("nt2", 4'd3, 32'h100, 32'd5, 32'd6, 32'h40, 1'b1, 32'h140);
        check_pred("nt2.pred", 32'h100);
        chk("nt2.plan", pred_target, 32'h104);

        // signed vs unsigned compares
        resolve("slt", 4'd4, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b0, 32'h0);
        resolve("sltu", 4'd5, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b0, 32'h0);
        resolve("sgeu", 4'd7, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b0, 32'h0);
        resolve("sge", 4'd6, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b0, 32'h0);

        // JALR target clears bit 0
        resolve("jalr_ok", 4'd8, 32'h300, 32'h2001, 32'd0, 32'd4, 1'b1, 32'h2004);
        resolve("jalr_bad", 4'd8, 32'h300, 32'h2001, 32'd0, 32'd4, 1'b1, 32'h3000);
        chk("jalr.plan", redirect_pc, 32'h2004);
        resolve("jal", 4'd1, 32'h304, 32'd0, 32'd0, 32'hFFFF_FFF0, 1'b0, 32'h0);

        // wrong-path op held in the redirect cycle
        drive_ex("sq", 4'd3, 32'h400, 32'd7, 32'd7, 32'h20, 1'b0, 32'h0);
        @(posedge clk); #1;
        ex_pc = 32'h480; ex_branch_sel = 4'd2; ex_sr1 = 32'd1; ex_sr2 = 32'd2;
        ex_imm = 32'h80; ex_pred_taken = 1'b0;
        @(negedge clk);
        check_redirect("sq");
        @(posedge clk); #1;
        ex_valid = 1'b0;
        chk("sq.second", {31'd0, redirect}, 32'd0);
        chk("sq.rpc_hold", redirect_pc, 32'h420);
        @(negedge clk);
        check_pred("sq.tbl", 32'h480);

        // reset asserted during the redirect cycle
        drive_ex("rr", 4'd1, 32'h500, 32'd0, 32'd0, 32'h100, 1'b0, 32'h0);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        @(negedge clk);
        check_redirect("rr");
        rstn = 1'b0;
        #1;
        chk("rr.redir", {31'd0, redirect}, 32'd0);
        chk("rr.rpc", redirect_pc, 32'd0);
        model_reset();
        check_pred("rr.pred100", 32'h100);
        check_pred("rr.pred500", 32'h500);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // random mix, including aliasing PCs and non-branch encodings
        for (int i = 0; i < 60; i++) begin
            sel = 4'($urandom_range(0, 15));
            pc  = pcs[$urandom_range(0, 3)];
            imm = {$urandom_range(0, 255), 2'b00} - 32'h200;
            pt  = m_pred(pc);
            if ($urandom_range(0, 3) == 0) pt = ~pt;
            resolve("rnd", sel, pc, vals[$urandom_range(0, 3)], vals[$urandom_range(0, 3)], imm,
                    pt, pt ? (m_pred(pc) ? m_tgt[pc[7:2]] : pc + imm) : 32'h0);
        end

`ifdef BP_STATS_EN
        chk("stats.bcnt", branch_cnt, 32'(m_bcnt));
        chk("stats.mcnt", mispred_cnt, 32'(m_mcnt));
`else
        chk("stats.bcnt", branch_cnt, 32'd0);
        chk("stats.mcnt", mispred_cnt, 32'd0);
`endif
        chk("sb.drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised branch unit for the pipelined RV32 core.
- IF side: direct-mapped BHT of 2-bit saturating counters plus tagged BTB give a taken/target prediction for the fetch PC.
- EX side: resolves the branch using the core's branch_sel encoding, updates the tables, and emits a registered one-cycle redirect on mispredict.

Parameters:
- XLEN, 32, data/address width.
- BHT_DEPTH, 64, entries in BHT and BTB; power of two, 4..1024. IDX_W = log2(BHT_DEPTH).
- CNT_INIT, 2'b01, counter reset value (weakly not-taken).

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- if_valid  in  1  fetch PC valid.
- if_pc  in  XLEN  fetch PC.
- pred_taken  out  1  predicted taken.
- pred_target  out  XLEN  predicted target; pc+4 when not predicted taken.
- ex_valid  in  1  branch/jump in EX this cycle.
- ex_pc  in  XLEN  PC of EX instruction.
- ex_branch_sel  in  4  branch type (encoding below).
- ex_sr1, ex_sr2  in  XLEN  operands.
- ex_imm  in  XLEN  sign-extended offset.
- ex_pred_taken  in  1  prediction carried down the pipe.
- ex_pred_target  in  XLEN  predicted target carried down the pipe.
- redirect  out  1  mispredict pulse.
- redirect_pc  out  XLEN  correct next PC.
- branch_cnt, mispred_cnt  out  32 each  statistics (see Optional Feature).

Behaviour:
- branch_sel encoding:
  - 0 NPC (not a branch)
  - 1 OFFPC (JAL)
  - 2 NE
  - 3 EQ
  - 4 signed LT
  - 5 unsigned LT
  - 6 signed GE
  - 7 unsigned GE
  - 8 JALR
  - 9..15 treated as NPC
- Index and tag:
  - idx = pc[IDX_W+1:2].
  - tag = pc[XLEN-1:IDX_W+2].
  - pc[1:0] ignored.
- Predict (combinational from table state):
  - hit = btb_valid[idx] && btb_tag[idx]==tag.
  - pred_taken = if_valid && hit && cnt[idx][1].
  - pred_target = pred_taken ? btb_target[idx] : if_pc+4.
- Resolve (EX, combinational):
  - Comparisons are full XLEN: signed via $signed, unsigned native.
  - OFFPC and JALR are always taken.
  - Target: OFFPC/conditional = ex_pc+ex_imm; JALR = (ex_sr1+ex_imm) & ~1.
  - All additions wrap modulo 2^XLEN.
- Mispredict when ex_valid && sel!=NPC and either:
  - actual_taken != ex_pred_taken, or
  - both taken and ex_pred_target != actual target.
- Redirect:
  - Registered; redirect is high for exactly the cycle after the mispredicting EX cycle.
  - redirect_pc = actual_taken ? target : ex_pc+4, held until the next redirect.
- Table update on the clock edge when ex_valid && sel!=NPC (and not squashed):
  - Counter: taken → saturating +1 (max 2'b11); not taken → saturating -1 (min 2'b00).
  - Taken: BTB entry written (valid=1, tag, target), overwriting any alias.
  - Not taken: BTB entry untouched.
- Squash: ex_valid during a cycle where redirect=1 is wrong-path; it is ignored entirely (no update, no redirect, no count).
- Read-during-write: IF lookup in the same cycle as an update to the same idx returns the pre-update value.
- Reset (async, any time, including mid-redirect):
  - redirect=0, redirect_pc=0.
  - All btb_valid=0, all counters=CNT_INIT, counters 0.
  - Predictions are therefore not-taken after reset.
  - Reset deassertion is synchronised externally.

Optional Feature:
- Macro BP_STATS_EN.
- Defined:
  - branch_cnt increments on every non-squashed resolved branch (sel!=NPC).
  - mispred_cnt increments on every mispredict.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: no counter flops; both ports tied to 0.

Test Plan:
- Reset, then if_pc=0x100 → pred_taken=0, pred_target=0x104; redirect=0.
- BEQ at 0x100, sr1=sr2=5, imm=0x40, ex_pred_taken=0 → next cycle redirect=1, redirect_pc=0x140, for one cycle only. Subsequent lookup of 0x100 after a second taken resolve → pred_taken=1, pred_target=0x140.
- Same BEQ resolved taken 4 times, then 1 not-taken (sr1≠sr2) → counter 11→10, still predicted taken. A second not-taken (10→01) → predicted not-taken; each not-taken resolve with ex_pred_taken=1 redirects to 0x104.
- Sign checks with sr1=0xFFFF_FFFF, sr2=1:
  - sel=4 (signed LT) → taken.
  - sel=5 (unsigned LT) → not taken.
  - sel=7 (unsigned GE) → taken.
  - sel=6 (signed GE) → not taken.
- JALR, sr1=0x2001, imm=4, ex_pred_taken=1, ex_pred_target=0x2004 → no redirect. Same case with ex_pred_target=0x3000 → redirect_pc=0x2004.
- Wrong-path/reset cases:
  - ex_valid mispredict held high in the redirect cycle → no second redirect, tables unchanged.
  - rstn low during the redirect cycle → redirect=0 immediately.
  - With BP_STATS_EN: counts match the bench model.
